// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the sub-word memory access sequencer
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] LANE_WORD_MASK = 32'hFFFF_FFFF;

    // size=11 has no defined lane, so it is rejected together with unaligned halves/words
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            SZ_WORD: is_misaligned = (offset != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] val, input logic [1:0] size,
                                           input logic sign_ext);
        case (size)
            SZ_BYTE: extend = {{24{sign_ext & val[7]}}, val[7:0]};
            SZ_HALF: extend = {{16{sign_ext & val[15]}}, val[15:0]};
            default: extend = val;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - lane insert for sub-word stores and lane extract for loads
module mem_lane_merge
    import mem_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    output logic [31:0] merged,
    output logic [31:0] lane_val
);

    logic [4:0]  shift;
    logic [31:0] low_mask;
    logic [31:0] lane_mask;

    // Big-endian mirrors the lane position: 3-offset equals ~offset for two bits
    always_comb begin
        shift    = 5'd0;
        low_mask = LANE_WORD_MASK;
        case (size)
            SZ_BYTE: begin
                low_mask = LANE_BYTE_MASK;
                shift    = (BIG_ENDIAN != 0) ? {~offset, 3'b000} : {offset, 3'b000};
            end
            SZ_HALF: begin
                low_mask = LANE_HALF_MASK;
                shift    = (BIG_ENDIAN != 0) ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
            end
            default: begin
                low_mask = LANE_WORD_MASK;
                shift    = 5'd0;
            end
        endcase
        lane_mask = low_mask << shift;
        merged    = (word & ~lane_mask) | ((wdata & low_mask) << shift);
        lane_val  = (word >> shift) & low_mask;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer with read-modify-write for byte and half stores
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misalign,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t      state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] merged;
    logic [31:0] lane_val;

    mem_lane_merge #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .word    (mem_rdata),
        .wdata   (r_wdata),
        .offset  (r_off),
        .size    (r_size),
        .merged  (merged),
        .lane_val(lane_val)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            misalign  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_we      <= 1'b0;
            r_size    <= SZ_BYTE;
            r_sext    <= 1'b0;
            r_off     <= 2'b00;
            r_wdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        r_we     <= we;
                        r_size   <= size;
                        r_sext   <= sign_ext;
                        r_off    <= addr[1:0];
                        r_wdata  <= wdata;
                        busy     <= 1'b1;
                        misalign <= 1'b0;
                        if (is_misaligned(size, addr[1:0])) begin
                            misalign <= 1'b1;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else if (we && size == SZ_WORD) begin
                            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= wdata;
                            mem_write <= 1'b1;
                            state     <= ST_WRITE;
                        end else begin
                            mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // mem_rdata now holds the word addressed on the accepting edge
                    if (r_we) begin
                        mem_wdata <= merged;
                        mem_write <= 1'b1;
                        state     <= ST_WRITE;
                    end else begin
                        rdata <= extend(lane_val, r_size, r_sext);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    mem_write <= 1'b0;
                    done      <= 1'b1;
                    state     <= ST_DONE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl with a dmemory32 model
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:16383];

    int total = 0;
    int bad   = 0;
    int lat, bcnt, wcnt, dcnt;

    mem_access_ctrl #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .BIG_ENDIAN(0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_write) ram[mem_addr[15:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[15:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done, then one IDLE cycle
    task automatic run(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [15:0] a, input logic [31:0] d,
                       output int l, output int b, output int wc);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge clock); #1;
        req = 1'b0;
        l = 1; b = 0; wc = 0;
        while (!done && l < 10) begin
            b += int'(busy); wc += int'(mem_write);
            @(posedge clock); #1;
            l++;
        end
        b += int'(busy); wc += int'(mem_write);
        @(posedge clock); #1;
        chk("idle_done_low", {31'd0, done}, 32'd0);
        chk("idle_busy_low", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 16'h0; wdata = 32'h0;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[16'h0010 >> 2] = 32'h1122_3344;
        ram[16'h0020 >> 2] = 32'h0000_F080;
        ram[16'h0040 >> 2] = 32'h5566_7788;
        @(posedge clock); @(posedge clock); #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run(1'b1, 2'b00, 1'b0, 16'h0011, 32'h0000_00AA, lat, bcnt, wcnt);
        chk("sb_latency", lat, 3);
        chk("sb_busy_cycles", bcnt, 3);
        chk("sb_write_cycles", wcnt, 1);
        chk("sb_ram", ram[4], 32'h1122_AA44);
        chk("sb_misalign", {31'd0, misalign}, 32'd0);

        run(1'b0, 2'b00, 1'b1, 16'h0020, 32'h0, lat, bcnt, wcnt);
        chk("lb_latency", lat, 2);
        chk("lb_write_cycles", wcnt, 0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);

        run(1'b0, 2'b00, 1'b0, 16'h0020, 32'h0, lat, bcnt, wcnt);
        chk("lbu_rdata", rdata, 32'h0000_0080);

        run(1'b0, 2'b01, 1'b1, 16'h0020, 32'h0, lat, bcnt, wcnt);
        chk("lh_latency", lat, 2);
        chk("lh_rdata", rdata, 32'hFFFF_F080);

        run(1'b1, 2'b01, 1'b0, 16'h0013, 32'h0000_BEEF, lat, bcnt, wcnt);
        chk("sh_mis_latency", lat, 1);
        chk("sh_mis_flag", {31'd0, misalign}, 32'd1);
        chk("sh_mis_write_cycles", wcnt, 0);
        chk("sh_mis_ram", ram[4], 32'h1122_AA44);
        chk("sh_mis_rdata_kept", rdata, 32'hFFFF_F080);

        run(1'b1, 2'b10, 1'b0, 16'h0030, 32'hDEAD_BEEF, lat, bcnt, wcnt);
        chk("sw_latency", lat, 2);
        chk("sw_write_cycles", wcnt, 1);
        chk("sw_ram", ram[12], 32'hDEAD_BEEF);
        chk("sw_misalign_cleared", {31'd0, misalign}, 32'd0);
        chk("sw_rdata_kept", rdata, 32'hFFFF_F080);

        run(1'b0, 2'b10, 1'b0, 16'h0030, 32'h0, lat, bcnt, wcnt);
        chk("lw_latency", lat, 2);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);

        run(1'b0, 2'b11, 1'b1, 16'h0030, 32'h0, lat, bcnt, wcnt);
        chk("sz11_latency", lat, 1);
        chk("sz11_misalign", {31'd0, misalign}, 32'd1);
        chk("sz11_rdata_kept", rdata, 32'hDEAD_BEEF);

        run(1'b1, 2'b10, 1'b0, 16'hFFFC, 32'hCAFE_F00D, lat, bcnt, wcnt);
        chk("top_sw_ram", ram[16383], 32'hCAFE_F00D);
        run(1'b0, 2'b00, 1'b0, 16'hFFFF, 32'h0, lat, bcnt, wcnt);
        chk("top_lbu_rdata", rdata, 32'h0000_00CA);
        run(1'b0, 2'b01, 1'b1, 16'hFFFE, 32'h0, lat, bcnt, wcnt);
        chk("top_lh_rdata", rdata, 32'hFFFF_CAFE);

        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 16'h0041; wdata = 32'h11;
        @(posedge clock); #1;
        req = 1'b0;
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mid_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        dcnt = 0; wcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            dcnt += int'(done); wcnt += int'(mem_write);
        end
        chk("rst_mid_no_done", dcnt, 0);
        chk("rst_mid_no_write", wcnt, 0);
        chk("rst_mid_ram", ram[16], 32'h5566_7788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
